alu_seq: RTL and testbench

Execution sequencer driving the combinational 4-bit `alu` from the opposite side of its interface. It accepts one 8-bit instruction per handshake and reads operands from a 4×4-bit register file. It presents them to the ALU, holds them for a programmable settle time covering the ALU's ~51 ns critical path, then captures RES/eq/ovf into the destination register and the Z/V flags. It sits between the instruction fetch stage and the `alu` instance in the 4-bit CPU.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/regfile_4x4.sv | 31 +++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq execution sequencer: opcodes, FSM states
// and INSTR field positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_NAND = 2'b01,
    OP_CMP  = 2'b10,
    OP_LDI  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS_MSB  = 3;
  localparam int unsigned RS_LSB  = 2;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  function automatic opcode_e instr_op(input logic [7:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

  function automatic logic [1:0] instr_rd(input logic [7:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [7:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [3:0] instr_imm(input logic [7:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// 4x4-bit register file: two combinational operand read ports, one debug read
// port, one synchronous write port, asynchronous active-low clear.
module regfile_4x4 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  output logic [3:0] rdata_a_o,
  input  logic [1:0] raddr_b_i,
  output logic [3:0] rdata_b_o,
  input  logic [1:0] dbg_addr_i,
  output logic [3:0] dbg_data_o
);

  logic [3:0] regs_q [4];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq.sv
// Execution sequencer for the external combinational 4-bit alu: latches
// operands, waits SETTLE_CYCLES, then captures result and flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] INSTR,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [3:0] ALU_A,
  output logic [3:0] ALU_B,
  output logic       alu_sel,
  input  logic [3:0] ALU_RES,
  input  logic       alu_eq,
  input  logic       alu_ovf,
  output logic       done,
  output logic [3:0] RES,
  output logic       z,
  output logic       v,
  input  logic [1:0] DBG_ADDR,
  output logic [3:0] DBG_DATA
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_a_q, alu_b_q;
  logic       sel_q;
  opcode_e    op_q;
  logic [1:0] rd_q;
  logic [3:0] res_q;
  logic       z_q, v_q;

  opcode_e    in_op;
  logic [1:0] in_rd, in_rs;
  logic [3:0] in_imm;
  logic [3:0] rf_a, rf_b;
  logic       accept, capture;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [3:0] rf_wdata;

  assign in_op  = instr_op(INSTR);
  assign in_rd  = instr_rd(INSTR);
  assign in_rs  = instr_rs(INSTR);
  assign in_imm = instr_imm(INSTR);

  assign accept  = instr_valid && (state_q == ST_IDLE);
  assign capture = (state_q == ST_WAIT) && (cnt_q == 4'(SETTLE_CYCLES - 1));

  // LDI writes at accept, ADD/NAND at capture; the two never coincide.
  assign rf_we    = (accept && (in_op == OP_LDI)) ||
                    (capture && ((op_q == OP_ADD) || (op_q == OP_NAND)));
  assign rf_waddr = accept ? in_rd  : rd_q;
  assign rf_wdata = accept ? in_imm : ALU_RES;

  regfile_4x4 u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (in_rd),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (in_rs),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (DBG_ADDR),
    .dbg_data_o (DBG_DATA)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (accept) begin
          cnt_d   = '0;
          state_d = (in_op == OP_LDI) ? ST_RETIRE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (capture) state_d = ST_RETIRE;
      end
      ST_RETIRE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      sel_q   <= 1'b0;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      if (accept && (in_op != OP_LDI)) begin
        alu_a_q <= rf_a;
        alu_b_q <= rf_b;
        sel_q   <= (in_op == OP_NAND);
        op_q    <= in_op;
        rd_q    <= in_rd;
      end
      if (accept && (in_op == OP_LDI)) res_q <= in_imm;
      if (capture) begin
        res_q <= ALU_RES;
        case (op_q)
          OP_ADD: begin
            z_q <= (ALU_RES == '0);
            v_q <= alu_ovf;
          end
          OP_NAND: z_q <= (ALU_RES == '0);
          OP_CMP:  z_q <= alu_eq;
          default: ;
        endcase
      end
    end
  end

  assign ALU_A   = alu_a_q;
  assign ALU_B   = alu_b_q;
  assign alu_sel = sel_q;
  assign RES     = res_q;
  assign z       = z_q;
  assign v       = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a slow ALU stand-in and an
// instruction-level reference model of the register file and flags.
module tb_alu_seq;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] INSTR;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] ALU_A, ALU_B;
  logic       alu_sel;
  logic [3:0] ALU_RES = '0;
  logic       alu_eq = 1'b0;
  logic       alu_ovf = 1'b0;
  logic       done;
  logic [3:0] RES;
  logic       z, v;
  logic [1:0] DBG_ADDR;
  logic [3:0] DBG_DATA;

  alu_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .INSTR       (INSTR),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .alu_sel     (alu_sel),
    .ALU_RES     (ALU_RES),
    .alu_eq      (alu_eq),
    .alu_ovf     (alu_ovf),
    .done        (done),
    .RES         (RES),
    .z           (z),
    .v           (v),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA)
  );

  always #5 clk = ~clk;

  // ALU stand-in: outputs follow operand changes only after 1.5 clock periods,
  // so an early capture sees stale values.
  logic [3:0] s1_res = '0;
  logic       s1_eq = 1'b0, s1_ovf = 1'b0;
  always @(negedge clk) begin
    logic [4:0] sum;
    sum = {1'b0, ALU_A} + {1'b0, ALU_B};
    ALU_RES <= s1_res;
    alu_eq  <= s1_eq;
    alu_ovf <= s1_ovf;
    s1_res  <= alu_sel ? ~(ALU_A & ALU_B) : sum[3:0];
    s1_eq   <= (ALU_A == ALU_B);
    s1_ovf  <= !alu_sel && (ALU_A[3] == ALU_B[3]) && (sum[3] != ALU_A[3]);
  end

  int unsigned n_vec = 0, n_err = 0;
  int unsigned n_done = 0, n_issued = 0;

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers and flags.
  int mR[4];
  int mRes, mZ, mV;

  function automatic int to_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mR[i] = 0;
    mRes = 0; mZ = 0; mV = 0;
  endtask

  task automatic model_exec(input int op, input int rd, input int rs, input int imm);
    int a, b, r, s;
    a = mR[rd]; b = mR[rs];
    case (op)
      0: begin
        r = (a + b) % 16;
        s = to_signed4(a) + to_signed4(b);
        mR[rd] = r; mRes = r; mZ = (r == 0); mV = (s > 7 || s < -8);
      end
      1: begin
        r = 15 - (a & b);
        mR[rd] = r; mRes = r; mZ = (r == 0);
      end
      2: begin
        mRes = (a + b) % 16; mZ = (a == b);
      end
      default: begin
        mR[rd] = imm; mRes = imm;
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      DBG_ADDR = 2'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), 16'(DBG_DATA), 16'(mR[i]));
    end
  endtask

  task automatic issue(input int op, input int rd, input int rs, input int imm, input bit hold);
    logic [7:0] ins;
    int ea, eb, exp_lat, lat;
    bit got;
    ea = mR[rd]; eb = mR[rs];
    ins = {2'(op), 2'(rd), 4'(imm)};
    if (op != 3) ins[3:2] = 2'(rs);
    @(negedge clk);
    check("done_single_pulse", 16'(done), 16'd0);
    check("ready_idle", 16'(instr_ready), 16'd1);
    INSTR = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
    model_exec(op, rd, rs, imm);
    n_issued++;
    exp_lat = (op == 3) ? 1 : int'(SETTLE) + 1;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        lat = c;
      end else begin
        check("ready_busy", 16'(instr_ready), 16'd0);
        if (op != 3) begin
          check("alu_a_hold", 16'(ALU_A), 16'(ea));
          check("alu_b_hold", 16'(ALU_B), 16'(eb));
          check("alu_sel", 16'(alu_sel), 16'(op == 1));
        end
      end
    end
    check($sformatf("latency_op%0d", op), 16'(lat), 16'(exp_lat));
    if (got) begin
      check("ready_retire", 16'(instr_ready), 16'd0);
      check($sformatf("res_op%0d", op), 16'(RES), 16'(mRes));
      check("z_flag", 16'(z), 16'(mZ));
      check("v_flag", 16'(v), 16'(mV));
      check_regs($sformatf("wb_op%0d", op));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    INSTR = '0;
    instr_valid = 1'b0;
    DBG_ADDR = '0;
    model_reset();
    #3;
    check("rst_alu_a", 16'(ALU_A), 16'd0);
    check("rst_alu_b", 16'(ALU_B), 16'd0);
    check("rst_sel", 16'(alu_sel), 16'd0);
    check("rst_res", 16'(RES), 16'd0);
    check("rst_zv", 16'({z, v}), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 16'(instr_ready), 16'd1);
    check_regs("rst");

    // Directed sequence
    issue(3, 1, 0, 5, 1'b0);
    issue(3, 0, 0, 8, 1'b0);
    issue(3, 1, 0, 8, 1'b0);
    issue(0, 0, 1, 0, 1'b0);   // 8+8 -> 0, z=1 v=1
    issue(3, 2, 0, 12, 1'b0);
    issue(3, 3, 0, 10, 1'b0);
    issue(1, 2, 3, 0, 1'b0);   // ~(C&A) = 7, v held
    issue(2, 1, 1, 0, 1'b0);   // CMP equal
    issue(2, 1, 3, 0, 1'b0);   // CMP 8 vs A, RES = 2
    issue(0, 3, 3, 0, 1'b0);   // rd == rs

    // Back-to-back with instr_valid held high throughout
    for (int i = 0; i < 8; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b1);
    instr_valid = 1'b0;

    for (int i = 0; i < 40; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b0);
    check("done_count", 16'(n_done), 16'(n_issued));

    // Reset in the middle of an ADD's settle window
    issue(3, 0, 0, 9, 1'b0);
    issue(3, 1, 0, 6, 1'b0);
    @(negedge clk);
    INSTR = 8'b00_00_01_00;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_busy", 16'(instr_ready), 16'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_alu_a", 16'(ALU_A), 16'd0);
    check("mrst_alu_b", 16'(ALU_B), 16'd0);
    check("mrst_sel", 16'(alu_sel), 16'd0);
    check("mrst_res", 16'(RES), 16'd0);
    check("mrst_zv", 16'({z, v}), 16'd0);
    check("mrst_done", 16'(done), 16'd0);
    check_regs("mrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_done", 16'(done), 16'd0);
      check("post_rst_ready", 16'(instr_ready), 16'd1);
    end
    issue(3, 2, 0, 7, 1'b0);
    issue(0, 2, 2, 0, 1'b0);   // 7+7 = E, signed overflow
    check("done_count_final", 16'(n_done), 16'(n_issued));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
